// File: rtl/skel_pkg.sv
// rtl/skel_pkg.sv - shared types and constants for the laser-line skeletoniser
package skel_pkg;

  localparam int FVH_F = 2;
  localparam int FVH_V = 1;
  localparam int FVH_H = 0;

  localparam int DEF_COL_W = 10;
  localparam int DEF_ROW_W = 9;

  typedef enum logic [1:0] {
    S_DARK = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } run_state_t;

  // One per-line result as seen by the triangulation stage (default widths).
  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W:0]   midpoint_x2;
    logic [DEF_COL_W-1:0] run_len;
    logic                 found;
  } skel_result_t;

endpackage

// File: rtl/skel_run_tracker.sv
// rtl/skel_run_tracker.sv - per-line run FSM with gap bridging and best-run register
// best_sum/best_len already include a run being committed this cycle, so a flush is visible at once.
module skel_run_tracker
  import skel_pkg::*;
#(
  parameter int COL_W   = 10,
  parameter int GAP_TOL = 3,
  parameter int MIN_RUN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             lit,
  input  logic [COL_W-1:0] col,
  input  logic             flush,
  input  logic             clear,
  output logic [COL_W:0]   best_sum,
  output logic [COL_W-1:0] best_len
);

  localparam int GAP_W = (GAP_TOL < 1) ? 1 : $clog2(GAP_TOL + 1);

  run_state_t       r_state;
  logic [COL_W-1:0] r_start;
  logic [COL_W-1:0] r_end;
  logic [GAP_W-1:0] r_gap;
  logic [COL_W:0]   r_best_sum;
  logic [COL_W-1:0] r_best_len;

  logic [COL_W-1:0] w_len;
  logic [COL_W:0]   w_sum;
  logic             w_better;
  logic             w_gap_close;
  logic             w_commit;

  assign w_len       = r_end - r_start + COL_W'(1);
  assign w_sum       = {1'b0, r_start} + {1'b0, r_end};
  assign w_better    = (w_len >= COL_W'(MIN_RUN)) && (w_len > r_best_len);
  assign w_gap_close = accept && !lit && (r_state == S_GAP) && (r_gap == GAP_W'(GAP_TOL));
  assign w_commit    = (w_gap_close || (flush && (r_state != S_DARK))) && w_better;

  assign best_sum = w_commit ? w_sum : r_best_sum;
  assign best_len = w_commit ? w_len : r_best_len;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state    <= S_DARK;
      r_start    <= '0;
      r_end      <= '0;
      r_gap      <= '0;
      r_best_sum <= '0;
      r_best_len <= '0;
    end else begin
      if (w_commit) begin
        r_best_sum <= w_sum;
        r_best_len <= w_len;
      end
      if (accept) begin
        case (r_state)
          S_DARK: begin
            if (lit) begin
              r_start <= col;
              r_end   <= col;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (lit) begin
              r_end <= col;
            end else begin
              r_gap   <= GAP_W'(1);
              r_state <= S_GAP;
            end
          end
          S_GAP: begin
            // r_end only moves on lit pixels, so trailing gap pixels never lengthen a run.
            if (lit) begin
              r_end   <= col;
              r_state <= S_RUN;
            end else if (r_gap == GAP_W'(GAP_TOL)) begin
              r_state <= S_DARK;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
          default: r_state <= S_DARK;
        endcase
      end
    end
  end

endmodule

// File: rtl/skeletonize_multi.sv
// rtl/skeletonize_multi.sv - thresholds luma, finds the longest gap-bridged lit run per line
// and emits row, half-pixel midpoint, length and found flag with a one-cycle strobe.
module skeletonize_multi
  import skel_pkg::*;
#(
  parameter int              PX_W    = 8,
  parameter logic [PX_W-1:0] THRESH  = 'h80,
  parameter int              GAP_TOL = 3,
  parameter int              MIN_RUN = 2,
  parameter int              COL_W   = DEF_COL_W,
  parameter int              ROW_W   = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       fvh_in,
  input  logic             dv_in,
  input  logic [PX_W-1:0]  px_in,
  output logic [ROW_W-1:0] current_row,
  output logic [COL_W:0]   midpoint_x2,
  output logic [COL_W-1:0] run_len,
  output logic             found,
  output logic             line_valid
);

  logic [2:0]       r_last_fvh;
  logic [ROW_W-1:0] r_row_cnt;
  logic             r_line_active;
  logic [COL_W-1:0] r_col;
  logic             r_col_full;
  logic [ROW_W-1:0] r_current_row;
  logic [COL_W:0]   r_midpoint_x2;
  logic [COL_W-1:0] r_run_len;
  logic             r_found;
  logic             r_line_valid;

  logic             w_new_frame;
  logic             w_new_line;
  logic             w_accept;
  logic             w_lit;
  logic             w_flush;
  logic             w_clear;
  logic [COL_W:0]   w_best_sum;
  logic [COL_W-1:0] w_best_len;
  logic             w_unused_f;

  assign w_new_frame = fvh_in[FVH_V] & ~r_last_fvh[FVH_V];
  assign w_new_line  = fvh_in[FVH_H] & ~r_last_fvh[FVH_H];
  assign w_unused_f  = fvh_in[FVH_F] ^ r_last_fvh[FVH_F];

  // Once the pixel at the last column index is taken, the rest of the line is dropped.
  assign w_accept = dv_in & ~w_new_frame & ~w_new_line & ~r_col_full;
  assign w_lit    = (px_in >= THRESH);
  assign w_flush  = w_new_line & ~w_new_frame & r_line_active;
  assign w_clear  = w_new_line | w_new_frame;

  skel_run_tracker #(
    .COL_W   (COL_W),
    .GAP_TOL (GAP_TOL),
    .MIN_RUN (MIN_RUN)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .accept   (w_accept),
    .lit      (w_lit),
    .col      (r_col),
    .flush    (w_flush),
    .clear    (w_clear),
    .best_sum (w_best_sum),
    .best_len (w_best_len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_fvh    <= '0;
      r_row_cnt     <= '0;
      r_line_active <= 1'b0;
      r_col         <= '0;
      r_col_full    <= 1'b0;
      r_current_row <= '0;
      r_midpoint_x2 <= '0;
      r_run_len     <= '0;
      r_found       <= 1'b0;
      r_line_valid  <= 1'b0;
    end else begin
      r_last_fvh   <= fvh_in;
      r_line_valid <= 1'b0;
      if (w_new_frame) begin
        r_row_cnt     <= '0;
        r_line_active <= 1'b1;
        r_col         <= '0;
        r_col_full    <= 1'b0;
      end else if (w_new_line) begin
        if (r_line_active) begin
          r_current_row <= r_row_cnt;
          r_midpoint_x2 <= w_best_sum;
          r_run_len     <= w_best_len;
          r_found       <= (w_best_len != '0);
          r_line_valid  <= 1'b1;
          r_row_cnt     <= r_row_cnt + ROW_W'(1);
        end
        r_line_active <= 1'b1;
        r_col         <= '0;
        r_col_full    <= 1'b0;
      end else if (w_accept) begin
        if (r_col == {COL_W{1'b1}}) begin
          r_col_full <= 1'b1;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign current_row = r_current_row;
  assign midpoint_x2 = r_midpoint_x2;
  assign run_len     = r_run_len;
  assign found       = r_found;
  assign line_valid  = r_line_valid;

endmodule

// File: tb/tb_skeletonize_multi.sv
// tb/tb_skeletonize_multi.sv - table-driven line vectors plus frame and reset sequences
module tb_skeletonize_multi;
  import skel_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fvh_in;
  logic        dv_in;
  logic [7:0]  px_in;
  logic [8:0]  current_row;
  logic [10:0] midpoint_x2;
  logic [9:0]  run_len;
  logic        found;
  logic        line_valid;

  always #5 clk = ~clk;

  skeletonize_multi dut (
    .clk         (clk),
    .reset       (reset),
    .fvh_in      (fvh_in),
    .dv_in       (dv_in),
    .px_in       (px_in),
    .current_row (current_row),
    .midpoint_x2 (midpoint_x2),
    .run_len     (run_len),
    .found       (found),
    .line_valid  (line_valid)
  );

  typedef struct {
    int           a0, a1, b0, b1, len;
    logic [7:0]   litv;
    bit           alt;
    skel_result_t exp;
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   s0 = 0;

  always @(posedge clk) begin
    #1;
    if (line_valid === 1'b1) strobes++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic d, input logic [7:0] p);
    @(negedge clk);
    fvh_in = f;
    dv_in  = d;
    px_in  = p;
  endtask

  // With alt set, every valid pixel is preceded by an invalid cycle carrying bright data.
  task automatic send_line(input int a0, input int a1, input int b0, input int b1,
                           input int len, input logic [7:0] litv, input bit alt);
    for (int c = 0; c < len; c++) begin
      if (alt) drive(3'b000, 1'b0, 8'hFF);
      drive(3'b000, 1'b1, ((c >= a0 && c <= a1) || (c >= b0 && c <= b1)) ? litv : 8'h7F);
    end
  endtask

  task automatic pulse(input logic [2:0] f);
    s0 = strobes;
    drive(f, 1'b0, 8'h00);
  endtask

  task automatic expect_strobe(input string tag, input skel_result_t e);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, line_valid}, 32'd1);
    chk({tag, "_row"}, {23'd0, current_row}, {23'd0, e.row});
    chk({tag, "_mid"}, {21'd0, midpoint_x2}, {21'd0, e.midpoint_x2});
    chk({tag, "_len"}, {22'd0, run_len}, {22'd0, e.run_len});
    chk({tag, "_found"}, {31'd0, found}, {31'd0, e.found});
    fvh_in = 3'b000;
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'd0, line_valid}, 32'd0);
    chk({tag, "_hold_mid"}, {21'd0, midpoint_x2}, {21'd0, e.midpoint_x2});
    chk({tag, "_strobe_count"}, strobes - s0, 32'd1);
  endtask

  task automatic expect_none(input string tag);
    @(negedge clk);
    chk({tag, "_no_valid"}, {31'd0, line_valid}, 32'd0);
    fvh_in = 3'b000;
    @(negedge clk);
    chk({tag, "_no_valid2"}, {31'd0, line_valid}, 32'd0);
    chk({tag, "_strobe_count"}, strobes - s0, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{100, 109, 1, 0, 320, 8'hFF, 1'b0, '{9'd0, 11'd209, 10'd10, 1'b1}};
    vecs[1]  = '{50, 54, 58, 60, 128, 8'h80, 1'b0, '{9'd1, 11'd110, 10'd11, 1'b1}};
    vecs[2]  = '{50, 54, 59, 61, 128, 8'hFF, 1'b0, '{9'd2, 11'd104, 10'd5, 1'b1}};
    vecs[3]  = '{10, 14, 200, 204, 256, 8'hFF, 1'b0, '{9'd3, 11'd24, 10'd5, 1'b1}};
    vecs[4]  = '{300, 300, 1, 0, 320, 8'hFF, 1'b0, '{9'd4, 11'd0, 10'd0, 1'b0}};
    vecs[5]  = '{700, 719, 1, 0, 720, 8'hFF, 1'b0, '{9'd5, 11'd1419, 10'd20, 1'b1}};
    vecs[6]  = '{700, 719, 1, 0, 720, 8'hFF, 1'b1, '{9'd6, 11'd1419, 10'd20, 1'b1}};
    vecs[7]  = '{10, 14, 1, 0, 18, 8'hFF, 1'b0, '{9'd7, 11'd24, 10'd5, 1'b1}};
    vecs[8]  = '{5, 7, 11, 12, 40, 8'hC0, 1'b0, '{9'd8, 11'd17, 10'd8, 1'b1}};
    vecs[9]  = '{1, 0, 1, 0, 30, 8'hFF, 1'b0, '{9'd9, 11'd0, 10'd0, 1'b0}};
    vecs[10] = '{0, 1, 1, 0, 10, 8'h80, 1'b0, '{9'd10, 11'd1, 10'd2, 1'b1}};

    reset  = 1'b1;
    fvh_in = 3'b000;
    dv_in  = 1'b0;
    px_in  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, line_valid}, 32'd0);
    chk("rst_row", {23'd0, current_row}, 32'd0);
    chk("rst_mid", {21'd0, midpoint_x2}, 32'd0);
    chk("rst_len", {22'd0, run_len}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    reset = 1'b0;

    pulse(3'b010);
    expect_none("frame0");

    for (int i = 0; i < 11; i++) begin
      send_line(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, vecs[i].len,
                vecs[i].litv, vecs[i].alt);
      pulse(3'b001);
      expect_strobe($sformatf("vec%0d", i), vecs[i].exp);
    end

    // New frame coinciding with new line discards the open line and restarts rows.
    send_line(0, 5, 1, 0, 30, 8'hFF, 1'b0);
    pulse(3'b011);
    expect_none("frame_cut");
    send_line(100, 109, 1, 0, 120, 8'hFF, 1'b0);
    pulse(3'b001);
    expect_strobe("f2_row0", '{9'd0, 11'd209, 10'd10, 1'b1});
    send_line(50, 54, 1, 0, 60, 8'hFF, 1'b0);
    pulse(3'b001);
    expect_strobe("f2_row1", '{9'd1, 11'd104, 10'd5, 1'b1});
    for (int r = 2; r < 5; r++) begin
      send_line(2, 3 + r, 1, 0, 20, 8'hFF, 1'b0);
      pulse(3'b001);
      expect_strobe($sformatf("f2_row%0d", r),
                    '{9'(r), 11'(5 + r), 10'(r + 2), 1'b1});
    end

    // Reset in the middle of a run on row 5.
    s0 = strobes;
    for (int c = 0; c < 6; c++) drive(3'b000, 1'b1, 8'hFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, line_valid}, 32'd0);
    chk("midrst_row", {23'd0, current_row}, 32'd0);
    chk("midrst_mid", {21'd0, midpoint_x2}, 32'd0);
    chk("midrst_len", {22'd0, run_len}, 32'd0);
    chk("midrst_found", {31'd0, found}, 32'd0);
    reset = 1'b0;
    send_line(0, 9, 1, 0, 12, 8'hFF, 1'b0);
    chk("midrst_strobes", strobes - s0, 32'd0);
    pulse(3'b001);
    expect_none("post_reset_line");
    pulse(3'b010);
    expect_none("post_reset_frame");
    send_line(100, 109, 1, 0, 120, 8'hFF, 1'b0);
    pulse(3'b001);
    expect_strobe("post_reset_row0", '{9'd0, 11'd209, 10'd10, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/skeletonize_multi.md
Name: skeletonize_multi

Overview:
- Parametrised successor to the per-row laser-line skeletoniser in the scanner video path.
- Consumes the 8-bit luma stream from the video decoder, thresholds each pixel, and bridges short dark gaps inside lit runs.
- Selects the longest qualifying lit run on every line and emits one result per line: row, half-pixel midpoint, run length, found flag.
- Feeds the triangulation/point-cloud stage. Unlike its predecessor it honours dv_in, flushes the open run at end of line, and reports a one-cycle valid strobe.

Parameters:
- PX_W, 8, pixel width.
- THRESH, 8'h80, a pixel is lit when px_in >= THRESH.
- GAP_TOL, 3, maximum number of consecutive dark pixels bridged inside a run.
- MIN_RUN, 2, minimum run length (pixels) to qualify as a candidate.
- COL_W, 10, width of the column counter.
- ROW_W, 9, width of the row counter.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- fvh_in, input, 3, {F,V,H}; a rising edge of bit1 marks a new frame, a rising edge of bit0 marks a new line.
- dv_in, input, 1, px_in is a valid active pixel this cycle.
- px_in, input, PX_W, pixel value.
- current_row, output, ROW_W, row index of the emitted result.
- midpoint_x2, output, COL_W+1, start+end of the best run (half-pixel units).
- run_len, output, COL_W, length of the best run; 0 when none found.
- found, output, 1, a qualifying run existed on the line.
- line_valid, output, 1, one-cycle strobe: the four outputs above are new.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: every output 0, FSM S_DARK, row counter 0, line_active 0, last_fvh 0.
- Edge detection: new_frame = fvh_in[1] & ~last_fvh[1]; new_line = fvh_in[0] & ~last_fvh[0]. last_fvh is registered every cycle.
- Pixel acceptance:
  - Accepted only when dv_in=1 and neither edge is active this cycle.
  - col is the index of the accepted pixel; it starts at 0 each line, increments per accepted pixel, and saturates at 2^COL_W-1.
  - Pixels arriving while col is saturated are ignored.
- FSM S_DARK:
  - lit pixel: start=end=col, go to S_RUN.
  - dark pixel: stay in S_DARK.
- FSM S_RUN:
  - lit pixel: end=col.
  - dark pixel: gap=1, go to S_GAP.
- FSM S_GAP:
  - lit pixel: end=col, go to S_RUN. Bridged pixels count toward the run.
  - dark pixel with gap<GAP_TOL: gap+1.
  - dark pixel with gap==GAP_TOL: commit the run, go to S_DARK.
- Commit rule:
  - len = end-start+1.
  - If len >= MIN_RUN and len > best_len, then best_len=len and best_sum=start+end.
  - Ties keep the earlier run.
  - A run ends at its last lit pixel; trailing gap pixels never extend it.
- new_line with line_active=1:
  - Flush: the open run (S_RUN or S_GAP) is committed in the same cycle.
  - On the next edge: current_row=row_cnt, midpoint_x2=best_sum, run_len=best_len, found=(best_len!=0); best_sum=0 when none found.
  - line_valid is high for exactly the following cycle.
  - row_cnt increments, wrapping at 2^ROW_W.
- new_line with line_active=0: no emission; line_active<=1.
- On every new_line: clear col, best and FSM, then begin the next line.
- new_frame: discard the in-progress line (no emission), row_cnt<=0, line_active<=1, clear col, best and FSM.
- new_frame together with new_line: new_frame behaviour only.
- Output hold: current_row, midpoint_x2, run_len and found hold their values between strobes.
- Latency: outputs update one cycle after the cycle in which new_line was detected.
- Arithmetic: start+end is computed at COL_W+1 bits and never overflows. Consumers use midpoint_x2>>1 for integer columns and bit0 for the half-pixel.
- Reset mid-line: the line is aborted and no strobe is produced.

Decomposition:
- Shared package skel_pkg:
  - run-FSM state encoding (S_DARK, S_RUN, S_GAP);
  - {F,V,H} bit-index constants;
  - the result record fields (row, midpoint_x2, run_len, found).
- Sub-module skel_run_tracker: the per-line run FSM, gap counter and best-run register.
  - Inputs: accept, lit, col, flush, clear.
  - Outputs: best_sum, best_len.
- Top level: edge detection, column and row counters, line_active, output registers and strobe.

Test Plan:
1. Lit pixels at cols 100–109 on row 0, else dark (THRESH 8'h80) -> strobe with current_row=0, midpoint_x2=209, run_len=10, found=1.
2. Lit 50–54, dark 55–57, lit 58–60 (GAP_TOL 3) -> single run 50–60: midpoint_x2=110, run_len=11. With dark 55–58 and lit 59–61 -> two runs of 5 and 3; best is 50–54: midpoint_x2=104, run_len=5.
3. Runs 10–14 and 200–204 (equal length) -> earlier kept: midpoint_x2=24. Lone lit pixel at col 300 (MIN_RUN 2) on a line otherwise dark -> found=0, run_len=0, midpoint_x2=0.
4. Lit from col 700 until new_line arrives (last accepted col 719) -> flushed: midpoint_x2=1419, run_len=20. dv_in low on alternate cycles -> same result, since columns count accepted pixels only.
5. Three lines, then new_frame, then two lines -> rows 0,1,2 then 0,1. No strobe for the line cut by new_frame. Exactly one strobe per line, each one cycle wide.
6. Reset asserted mid-run on row 5 -> all outputs 0 next cycle, no strobe; the first line after the next new_frame reports row 0.
